controlador_partida: RTL and testbench
======================================

# controlador_partida

Turn sequencer for the Connect-4 game: after start-player selection it owns the per-turn 10 s countdown, turns a player's one-hot column switch into a place request, and issues an automatic move to the leftmost free column when time runs out. It waits for the placer's acknowledge and samples the win detectors. It then either hands the turn to the other colour or latches the game result. It sits between the start-player selector, the piece placer, the win checker and the 7-segment and VGA outputs, and replaces the separate turn, timer and auto-play glue.

## Interface
Parameters:
- `TURN_SECONDS`, 10: countdown reload value (1..15).
- `ACK_TIMEOUT`, 4: cycles to wait for the placer's acknowledge.
- `NCOLS`, 7: number of board columns.

Ports:
- `clk` in 1: single clock (25 MHz VGA clock domain).
- `reset` in 1: synchronous, active-high.
- `listo` in 1: start-player selection done (level).
- `jugador_inicial` in 1: 1 = red starts.
- `tick_1s` in 1: one-cycle strobe per second, already in the `clk` domain.
- `place_pulse` in 1: one-cycle player confirm.
- `col_switch` in NCOLS: one-hot column selection.
- `col_full` in NCOLS: bit i = column i full.
- `valid_move` in 1: placer acknowledge (one cycle).
- `win_red`, `win_yellow` in 1: win detectors; valid on the cycle after `valid_move`.
- `place_req` out 1: one-cycle place request.
- `place_col` out 3: column index, held from `place_req` until the acknowledge or timeout.
- `is_red` out 1: current mover.
- `auto_move` out 1: current/last request was automatic.
- `seconds_left` out 4: countdown value for the displays.
- `timer_expired` out 1: one-cycle pulse.
- `bad_move` out 1: one-cycle pulse on a rejected manual selection.
- `ack_error` out 1: one-cycle pulse on acknowledge timeout.
- `game_over` out 1: game-over level.
- `winner` out 2: 00 none, 01 red, 10 yellow, 11 draw.

## Operation
States: IDLE, TURN, ISSUE, WAIT_ACK, CHECK, GAME_OVER.

- **IDLE**
  - Outputs are at their reset values.
  - When `listo`=1: `is_red` ← `jugador_inicial`, `seconds_left` ← TURN_SECONDS, go to TURN.
- **TURN**
  - `tick_1s` decrements `seconds_left`.
  - On a tick with `seconds_left`=1: `seconds_left` ← 0 and `timer_expired` pulses.
    - If any column is free: `auto_move` ← 1, `place_col` ← lowest free index, go to ISSUE.
    - If every column is full: `winner` ← 11, go to GAME_OVER.
  - On `place_pulse`:
    - If `col_switch` is exactly one-hot and that column is not full: `place_col` ← index, `auto_move` ← 0, go to ISSUE.
    - Otherwise `bad_move` pulses and the state stays TURN (countdown continues).
- **ISSUE**
  - `place_req`=1 for exactly one cycle, then go to WAIT_ACK with the wait counter cleared.
- **WAIT_ACK**
  - `valid_move` → go to CHECK.
  - After ACK_TIMEOUT cycles without it: `ack_error` pulses, `seconds_left` ← TURN_SECONDS, return to TURN with the same mover.
- **CHECK** (one cycle)
  - `win_red` only → `winner`=01.
  - `win_yellow` only → `winner`=10.
  - Both asserted → the mover's colour.
  - Neither, and `&col_full` → 11.
  - In any of the above cases, go to GAME_OVER.
  - Otherwise toggle `is_red`, reload `seconds_left`, go to TURN.
- **GAME_OVER**
  - `game_over`=1 and `winner` held.
  - Left only by `reset`.

Other rules:
- `tick_1s`, `place_pulse` and `valid_move` are ignored outside the states that use them.
- `valid_move` arriving in ISSUE is ignored.

## Timing
- Reset, effective on the next edge and in any state including mid-handshake:
  - Returns to IDLE.
  - `place_req`, `auto_move`, `timer_expired`, `bad_move`, `ack_error`, `game_over` = 0.
  - `winner`=00, `is_red`=0, `seconds_left`=0, `place_col`=0.
- Manual path: `place_pulse` in cycle n → `place_req` in n+1. `valid_move` in cycle m → CHECK in m+1 → TURN or GAME_OVER in m+2.
- Expiry: the tick in cycle n produces `timer_expired` in n+1 and `place_req` in n+2.
- Simultaneous valid `place_pulse` and the final tick: the manual move wins, with no `timer_expired` and no auto move.
- A `place_pulse` with an invalid selection in the same cycle as the final tick: `bad_move` pulses and the auto move still proceeds.
- All outputs are registered; the pulse outputs are exactly one cycle wide.

## Structure
- `connect4_pkg`:
  - state enum `partida_state_t`
  - winner codes `W_NONE`, `W_RED`, `W_YELLOW`, `W_DRAW`
  - `NCOLS`, `NROWS`
  - column index type
- Sub-module `selector_columna`, combinational, shared by the manual and auto paths. Outputs:
  - `onehot_ok` and `onehot_idx` from `col_switch`
  - `free_any` and `free_idx` from `~col_full`

## Test plan
- **Manual move:** `jugador_inicial`=1, `listo`=1, then `col_switch`=0000100 with a pulse → `place_req` with `place_col`=2. After `valid_move`, no win → `is_red`=0, `seconds_left`=10.
- **Timeout:** 10 ticks with no input, `col_full`=0000011 → `timer_expired`, auto `place_req` with `place_col`=2, `auto_move`=1.
- **Rejected selections:** `col_switch`=0000110 or a full target column → `bad_move` pulse, no `place_req`, countdown continues.
- **Missing acknowledge:** no `valid_move` → `ack_error` after 4 cycles, same mover, `seconds_left`=10.
- **Results:**
  - `win_yellow` in CHECK → `winner`=10, `game_over` held through later pulses and ticks.
  - All columns full in CHECK → `winner`=11.
- **Reset and simultaneity:**
  - Reset asserted in WAIT_ACK → IDLE with all outputs at reset values.
  - A valid pulse coincident with the final tick → manual column chosen.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared Connect-4 types: board geometry, column index, turn-sequencer states
// and the winner encoding driven towards the displays.
package connect4_pkg;

  localparam int NCOLS = 7;
  localparam int NROWS = 6;

  typedef logic [2:0] col_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    TURN,
    ISSUE,
    WAIT_ACK,
    CHECK,
    GAME_OVER
  } partida_state_t;

  localparam logic [1:0] W_NONE   = 2'b00;
  localparam logic [1:0] W_RED    = 2'b01;
  localparam logic [1:0] W_YELLOW = 2'b10;
  localparam logic [1:0] W_DRAW   = 2'b11;

endpackage

// File: rtl/selector_columna.sv
// Column decoding shared by the manual and automatic move paths: validates the
// one-hot switch selection and finds the leftmost column that still has room.
module selector_columna
  import connect4_pkg::*;
#(
  parameter int NCOLS = 7
) (
  input  logic [NCOLS-1:0] col_switch,
  input  logic [NCOLS-1:0] col_full,
  output logic             onehot_ok,
  output col_idx_t         onehot_idx,
  output logic             free_any,
  output col_idx_t         free_idx
);

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    onehot_idx = '0;
    free_idx   = '0;
    for (int i = NCOLS - 1; i >= 0; i--) begin
      if (col_switch[i]) onehot_idx = col_idx_t'(i);
      if (!col_full[i])  free_idx   = col_idx_t'(i);
    end
  end

  assign onehot_ok = $onehot(col_switch);
  assign free_any  = ~&col_full;

endmodule

// File: rtl/controlador_partida.sv
// Connect-4 turn sequencer: per-turn countdown, manual/automatic place requests,
// placer handshake with timeout, and latching of the game result.
module controlador_partida #(
  parameter int TURN_SECONDS = 10,
  parameter int ACK_TIMEOUT  = 4,
  parameter int NCOLS        = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             listo,
  input  logic             jugador_inicial,
  input  logic             tick_1s,
  input  logic             place_pulse,
  input  logic [NCOLS-1:0] col_switch,
  input  logic [NCOLS-1:0] col_full,
  input  logic             valid_move,
  input  logic             win_red,
  input  logic             win_yellow,
  output logic             place_req,
  output logic [2:0]       place_col,
  output logic             is_red,
  output logic             auto_move,
  output logic [3:0]       seconds_left,
  output logic             timer_expired,
  output logic             bad_move,
  output logic             ack_error,
  output logic             game_over,
  output logic [1:0]       winner
);
  import connect4_pkg::*;

  localparam int            AW        = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [3:0]    RELOAD    = 4'(TURN_SECONDS);
  localparam logic [AW-1:0] WAIT_LAST = AW'(ACK_TIMEOUT - 1);

  partida_state_t state_q, state_d;
  logic [AW-1:0]  wait_q, wait_d;
  logic           place_req_q, place_req_d;
  col_idx_t       place_col_q, place_col_d;
  logic           is_red_q, is_red_d;
  logic           auto_move_q, auto_move_d;
  logic [3:0]     secs_q, secs_d;
  logic           expired_q, expired_d;
  logic           bad_move_q, bad_move_d;
  logic           ack_error_q, ack_error_d;
  logic           game_over_q, game_over_d;
  logic [1:0]     winner_q, winner_d;

  logic     onehot_ok, free_any;
  col_idx_t onehot_idx, free_idx;
  logic     manual_ok, final_tick;
  logic [1:0] result;

  selector_columna #(.NCOLS(NCOLS)) u_sel (
    .col_switch(col_switch),
    .col_full  (col_full),
    .onehot_ok (onehot_ok),
    .onehot_idx(onehot_idx),
    .free_any  (free_any),
    .free_idx  (free_idx)
  );

  assign manual_ok  = place_pulse && onehot_ok && !col_full[onehot_idx];
  assign final_tick = tick_1s && (secs_q == 4'd1);

  // A double win goes to the colour that just moved.
  always_comb begin
    result = W_NONE;
    if (win_red && win_yellow)  result = is_red_q ? W_RED : W_YELLOW;
    else if (win_red)           result = W_RED;
    else if (win_yellow)        result = W_YELLOW;
    else if (&col_full)         result = W_DRAW;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      place_req_q <= 1'b0;
      place_col_q <= '0;
      is_red_q    <= 1'b0;
      auto_move_q <= 1'b0;
      secs_q      <= '0;
      expired_q   <= 1'b0;
      bad_move_q  <= 1'b0;
      ack_error_q <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= W_NONE;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      place_req_q <= place_req_d;
      place_col_q <= place_col_d;
      is_red_q    <= is_red_d;
      auto_move_q <= auto_move_d;
      secs_q      <= secs_d;
      expired_q   <= expired_d;
      bad_move_q  <= bad_move_d;
      ack_error_q <= ack_error_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  // Zero seconds in TURN marks an expiry one cycle old: the auto move issues now.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (listo) state_d = TURN;
      TURN: begin
        if (secs_q == 4'd0)  state_d = free_any ? ISSUE : GAME_OVER;
        else if (manual_ok)  state_d = ISSUE;
      end
      ISSUE:     state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (valid_move)              state_d = CHECK;
        else if (wait_q == WAIT_LAST) state_d = TURN;
      end
      CHECK:     state_d = (result != W_NONE) ? GAME_OVER : TURN;
      GAME_OVER: state_d = GAME_OVER;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    place_req_d = 1'b0;
    expired_d   = 1'b0;
    bad_move_d  = 1'b0;
    ack_error_d = 1'b0;
    place_col_d = place_col_q;
    is_red_d    = is_red_q;
    auto_move_d = auto_move_q;
    secs_d      = secs_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    wait_d      = wait_q;
    unique case (state_q)
      IDLE: begin
        if (listo) begin
          is_red_d = jugador_inicial;
          secs_d   = RELOAD;
        end
      end
      TURN: begin
        if (secs_q == 4'd0) begin
          if (free_any) begin
            place_req_d = 1'b1;
            auto_move_d = 1'b1;
            place_col_d = free_idx;
          end else begin
            winner_d    = W_DRAW;
            game_over_d = 1'b1;
          end
        end else begin
          if (manual_ok) begin
            place_req_d = 1'b1;
            auto_move_d = 1'b0;
            place_col_d = onehot_idx;
          end else if (place_pulse) begin
            bad_move_d = 1'b1;
          end
          // A valid move on the final tick pre-empts the expiry.
          if (final_tick && !manual_ok) begin
            secs_d    = 4'd0;
            expired_d = 1'b1;
          end else if (tick_1s && !final_tick) begin
            secs_d = secs_q - 4'd1;
          end
        end
      end
      ISSUE:     wait_d = '0;
      WAIT_ACK: begin
        if (!valid_move) begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WAIT_LAST) begin
            ack_error_d = 1'b1;
            secs_d      = RELOAD;
          end
        end
      end
      CHECK: begin
        if (result != W_NONE) begin
          winner_d    = result;
          game_over_d = 1'b1;
        end else begin
          is_red_d = ~is_red_q;
          secs_d   = RELOAD;
        end
      end
      GAME_OVER: ;
      default: ;
    endcase
  end

  assign place_req     = place_req_q;
  assign place_col     = place_col_q;
  assign is_red        = is_red_q;
  assign auto_move     = auto_move_q;
  assign seconds_left  = secs_q;
  assign timer_expired = expired_q;
  assign bad_move      = bad_move_q;
  assign ack_error     = ack_error_q;
  assign game_over     = game_over_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_controlador_partida.sv
// Scoreboard bench for controlador_partida: stimulus tasks push the expected
// output events, a negedge monitor pops and compares them as the DUT emits them.
module tb_controlador_partida;
  localparam int TS = 10;

  logic clk = 1'b0;
  logic reset = 1'b1, listo = 1'b0, jugador_inicial = 1'b0, tick_1s = 1'b0;
  logic place_pulse = 1'b0, valid_move = 1'b0, win_red = 1'b0, win_yellow = 1'b0;
  logic [6:0] col_switch = '0, col_full = '0;
  logic place_req, is_red, auto_move, timer_expired, bad_move, ack_error, game_over;
  logic [2:0] place_col;
  logic [3:0] seconds_left;
  logic [1:0] winner;

  always #5 clk = ~clk;

  controlador_partida #(.TURN_SECONDS(TS), .ACK_TIMEOUT(4), .NCOLS(7)) dut (
    .clk(clk), .reset(reset), .listo(listo), .jugador_inicial(jugador_inicial),
    .tick_1s(tick_1s), .place_pulse(place_pulse), .col_switch(col_switch),
    .col_full(col_full), .valid_move(valid_move), .win_red(win_red),
    .win_yellow(win_yellow), .place_req(place_req), .place_col(place_col),
    .is_red(is_red), .auto_move(auto_move), .seconds_left(seconds_left),
    .timer_expired(timer_expired), .bad_move(bad_move), .ack_error(ack_error),
    .game_over(game_over), .winner(winner)
  );

  typedef enum int {EV_EXP, EV_BAD, EV_ACKERR, EV_REQ, EV_OVER} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       col;
    bit       am;
    bit       red;
    int       win;
    int       secs;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad = 0;

  // Abstract game model: who moves, seconds on the clock, and the result.
  bit m_red;
  int m_secs;
  bit m_over;
  int m_winner;

  function automatic void push(ev_kind_t k, int col, bit am, bit red, int w, int s);
    ev_t e;
    e.kind = k; e.col = col; e.am = am; e.red = red; e.win = w; e.secs = s;
    q.push_back(e);
  endfunction

  task automatic observe(ev_kind_t k);
    ev_t e;
    bit  ok;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got event col=%0d auto=%0b red=%0b win=%0d secs=%0d, required no event",
               k.name(), place_col, auto_move, is_red, winner, seconds_left);
      return;
    end
    e  = q.pop_front();
    ok = (e.kind == k);
    case (k)
      EV_REQ:    ok = ok && place_col == e.col[2:0] && auto_move == e.am && is_red == e.red;
      EV_OVER:   ok = ok && winner == e.win[1:0];
      EV_ACKERR: ok = ok && is_red == e.red && seconds_left == e.secs[3:0];
      default:   ok = ok && seconds_left == e.secs[3:0];
    endcase
    if (!ok) begin
      bad++;
      $display("FAIL event_%s: got col=%0d auto=%0b red=%0b win=%0d secs=%0d, required %s col=%0d auto=%0b red=%0b win=%0d secs=%0d",
               k.name(), place_col, auto_move, is_red, winner, seconds_left,
               e.kind.name(), e.col, e.am, e.red, e.win, e.secs);
    end else begin
      $display("event %s col=%0d auto=%0b red=%0b win=%0d secs=%0d ok",
               k.name(), place_col, auto_move, is_red, winner, seconds_left);
    end
  endtask

  bit go_prev = 1'b0;
  always @(negedge clk) begin
    if (timer_expired === 1'b1)           observe(EV_EXP);
    if (bad_move === 1'b1)                observe(EV_BAD);
    if (ack_error === 1'b1)               observe(EV_ACKERR);
    if (place_req === 1'b1)               observe(EV_REQ);
    if (game_over === 1'b1 && !go_prev)   observe(EV_OVER);
    go_prev = (game_over === 1'b1);
  end

  task automatic chk(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drained();
    @(negedge clk);
    #1;
    chk("pending_events", q.size(), 0);
    q.delete();
    @(posedge clk);
    #1;
  endtask

  function automatic int low_free(logic [6:0] full);
    for (int i = 0; i < 7; i++) if (!full[i]) return i;
    return -1;
  endfunction

  function automatic int rand_free(logic [6:0] full);
    int c;
    do c = $urandom_range(0, 6); while (full[c]);
    return c;
  endfunction

  function automatic int expect_result(bit wr, bit wy, bit red, logic [6:0] full);
    if (wr && wy) return red ? 1 : 2;
    if (wr) return 1;
    if (wy) return 2;
    if (full == 7'h7f) return 3;
    return 0;
  endfunction

  task automatic start_game(bit starter);
    drained();
    reset = 1'b1; step(); step(); reset = 1'b0;
    chk("reset_outputs", int'({place_req, place_col, is_red, auto_move, seconds_left,
                               timer_expired, bad_move, ack_error, game_over, winner}), 0);
    jugador_inicial = starter; listo = 1'b1; step(); listo = 1'b0;
    m_red = starter; m_secs = TS; m_over = 1'b0; m_winner = 0;
    chk("start_is_red", is_red, m_red);
    chk("start_seconds", seconds_left, TS);
  endtask

  task automatic manual_move(int c);
    col_switch = 7'(1 << c); place_pulse = 1'b1;
    push(EV_REQ, c, 1'b0, m_red, 0, 0);
    step();
    place_pulse = 1'b0; col_switch = '0;
  endtask

  task automatic ack(bit wr, bit wy, logic [6:0] full_after);
    int w;
    step();
    valid_move = 1'b1; step(); valid_move = 1'b0;
    win_red = wr; win_yellow = wy; col_full = full_after;
    w = expect_result(wr, wy, m_red, full_after);
    if (w != 0) push(EV_OVER, 0, 1'b0, 1'b0, w, 0);
    step();
    win_red = 1'b0; win_yellow = 1'b0;
    if (w != 0) begin
      m_over = 1'b1; m_winner = w;
    end else begin
      m_red = !m_red; m_secs = TS;
      chk("next_is_red", is_red, m_red);
      chk("next_seconds", seconds_left, TS);
    end
  endtask

  // valid_move on the first cycle lands while the DUT is still issuing: ignored.
  task automatic no_ack();
    push(EV_ACKERR, 0, 1'b0, m_red, 0, TS);
    for (int i = 0; i < 5; i++) begin
      valid_move = (i == 0);
      tick_1s = 1'($urandom_range(0, 1));
      step();
    end
    valid_move = 1'b0; tick_1s = 1'b0;
    m_secs = TS;
    chk("ackerr_is_red", is_red, m_red);
    chk("ackerr_seconds", seconds_left, TS);
  endtask

  task automatic ticks(int k);
    for (int i = 0; i < k; i++) begin
      tick_1s = 1'b1; step(); tick_1s = 1'b0; step();
      m_secs--;
    end
  endtask

  task automatic bad_sel(logic [6:0] sel);
    push(EV_BAD, 0, 1'b0, 1'b0, 0, m_secs);
    col_switch = sel; place_pulse = 1'b1; step();
    place_pulse = 1'b0; col_switch = '0;
  endtask

  function automatic logic [6:0] rand_bad_sel();
    logic [6:0] s;
    if (col_full != 0 && $urandom_range(0, 1) == 1) begin
      int c;
      do c = $urandom_range(0, 6); while (!col_full[c]);
      s = 7'(1 << c);
    end else begin
      do s = 7'($urandom); while ($countones(s) == 1);
    end
    return s;
  endfunction

  task automatic timeout();
    ticks(m_secs - 1);
    push(EV_EXP, 0, 1'b0, 1'b0, 0, 0);
    if (col_full != 7'h7f) push(EV_REQ, low_free(col_full), 1'b1, m_red, 0, 0);
    else                   push(EV_OVER, 0, 1'b0, 1'b0, 3, 0);
    tick_1s = 1'b1; step(); tick_1s = 1'b0; step();
    m_secs = 0;
    if (col_full == 7'h7f) begin
      m_over = 1'b1; m_winner = 3;
    end
  endtask

  task automatic coincide(bit valid);
    logic [6:0] sel;
    int c;
    ticks(m_secs - 1);
    if (valid) begin
      c = rand_free(col_full);
      sel = 7'(1 << c);
      push(EV_REQ, c, 1'b0, m_red, 0, 0);
    end else begin
      sel = rand_bad_sel();
      push(EV_EXP, 0, 1'b0, 1'b0, 0, 0);
      push(EV_BAD, 0, 1'b0, 1'b0, 0, 0);
      push(EV_REQ, low_free(col_full), 1'b1, m_red, 0, 0);
    end
    tick_1s = 1'b1; place_pulse = 1'b1; col_switch = sel;
    step();
    tick_1s = 1'b0; place_pulse = 1'b0; col_switch = '0;
    if (!valid) step();
  endtask

  task automatic game_over_hold();
    drained();
    for (int i = 0; i < 4; i++) begin
      tick_1s = 1'b1; place_pulse = 1'b1; valid_move = 1'b1;
      col_switch = 7'(1 << low_free(7'h00));
      step();
    end
    tick_1s = 1'b0; place_pulse = 1'b0; valid_move = 1'b0; col_switch = '0;
    chk("over_level", game_over, 1);
    chk("over_winner", winner, m_winner);
  endtask

  task automatic random_ack();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0)      ack(1'b1, 1'b0, col_full);
    else if (r == 1) ack(1'b0, 1'b1, col_full);
    else if (r == 2) ack(1'b1, 1'b1, col_full);
    else if (r == 3) ack(1'b0, 1'b0, 7'h7f);
    else if (r < 7)  no_ack();
    else             ack(1'b0, 1'b0, col_full);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] mask;
    int act;
    step();

    // Directed: manual move, timeout with auto move, rejected selections, missing ack, yellow win.
    start_game(1'b1);
    col_full = '0; manual_move(2); ack(1'b0, 1'b0, 7'h00);
    col_full = 7'b0000011; timeout(); ack(1'b0, 1'b0, 7'b0000111);
    col_full = 7'b0000001;
    bad_sel(7'b0000110); bad_sel(7'b0000001); bad_sel(7'b0000000);
    ticks(3);
    chk("countdown_continues", seconds_left, m_secs);
    manual_move(4); no_ack();
    manual_move(5); ack(1'b0, 1'b1, 7'b0000001);
    game_over_hold();

    // Draw by expiry with a full board, then draw found in CHECK.
    start_game(1'b0);
    col_full = 7'h7f; timeout();
    game_over_hold();
    start_game(1'b0);
    col_full = '0; manual_move(0); ack(1'b0, 1'b0, 7'h7f);
    game_over_hold();

    // Reset while waiting for the acknowledge.
    start_game(1'b1);
    col_full = '0; manual_move(3); step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("midack_reset_outputs", int'({place_req, place_col, is_red, auto_move, seconds_left,
                                      timer_expired, bad_move, ack_error, game_over, winner}), 0);
    step();
    chk("idle_seconds", seconds_left, 0);

    // Final-tick coincidences.
    start_game(1'b0);
    col_full = '0; coincide(1'b1); ack(1'b0, 1'b0, 7'h00);
    col_full = 7'b0000001; coincide(1'b0); ack(1'b1, 1'b1, 7'b0000011);
    game_over_hold();

    // Randomized games.
    for (int g = 0; g < 6; g++) begin
      start_game(1'($urandom_range(0, 1)));
      for (int t = 0; t < 12 && !m_over; t++) begin
        do mask = 7'($urandom); while (mask == 7'h7f);
        col_full = mask;
        act = $urandom_range(0, 9);
        if (act < 2) begin
          bad_sel(rand_bad_sel());
        end else if (act < 4 && m_secs > 1) begin
          ticks($urandom_range(1, m_secs - 1));
        end else if (act < 7) begin
          manual_move(rand_free(col_full)); random_ack();
        end else if (act < 8) begin
          coincide(1'($urandom_range(0, 1))); random_ack();
        end else begin
          timeout(); random_ack();
        end
        drained();
      end
      if (!m_over) begin
        col_full = '0; manual_move(rand_free(col_full)); ack(1'b1, 1'b0, 7'h00);
      end
      game_over_hold();
    end

    drained();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
